// File: rtl/udp_clk_pkg.sv
// Shared types and helpers for the multi-channel reference-clock generator.
// Helpers work on a 64-bit word so any channel WIDTH up to 64 can use them.
package udp_clk_pkg;

    localparam int UDP_CLK_WIDTH = 32;
    localparam int FN_W          = 64;

    typedef logic [FN_W-1:0] fn_word_t;

    typedef struct packed {
        logic                     en;
        logic [UDP_CLK_WIDTH-1:0] period;
        logic [UDP_CLK_WIDTH-1:0] thresh;
        logic [UDP_CLK_WIDTH-1:0] phase;
    } chan_cfg_t;

    function automatic fn_word_t period_eff(input fn_word_t period);
        return (period < fn_word_t'(2)) ? fn_word_t'(2) : period;
    endfunction

    function automatic fn_word_t phase_eff(input fn_word_t phase, input fn_word_t per_eff);
        return (phase >= per_eff) ? '0 : phase;
    endfunction

endpackage

// File: rtl/udp_clk_chan.sv
// One clock channel: period counter, live/shadow config, wrap-aligned commit, registered outputs.
// Outputs lag the counter by one cycle; shadow writes are only offered while nothing is pending.
module udp_clk_chan
    import udp_clk_pkg::*;
#(
    parameter int WIDTH = UDP_CLK_WIDTH
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_thresh,
    input  logic [WIDTH-1:0] i_phase,
    input  logic             i_sync,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pending
);

    typedef struct packed {
        logic             en;
        logic [WIDTH-1:0] period;
        logic [WIDTH-1:0] thresh;
        logic [WIDTH-1:0] phase;
    } cfg_t;

    cfg_t             r_live;
    cfg_t             r_shadow;
    logic             r_pend;
    logic [WIDTH-1:0] r_cnt;

    logic [WIDTH-1:0] w_pe;
    logic [WIDTH-1:0] w_ph;
    logic [WIDTH-1:0] w_sh_pe;
    logic [WIDTH-1:0] w_sh_ph;
    logic             w_wrap;
    logic             w_commit;

    assign w_pe    = WIDTH'(period_eff(fn_word_t'(r_live.period)));
    assign w_ph    = WIDTH'(phase_eff(fn_word_t'(r_live.phase), fn_word_t'(w_pe)));
    assign w_sh_pe = WIDTH'(period_eff(fn_word_t'(r_shadow.period)));
    assign w_sh_ph = WIDTH'(phase_eff(fn_word_t'(r_shadow.phase), fn_word_t'(w_sh_pe)));

    // A disabled channel has no period boundary to wait for, so it commits at once.
    assign w_wrap   = r_live.en && (r_cnt == (w_pe - WIDTH'(1)));
    assign w_commit = r_pend && (!r_live.en || w_wrap);

    assign o_pending = r_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live   <= '0;
            r_shadow <= '0;
            r_pend   <= 1'b0;
            r_cnt    <= '0;
            o_clk    <= 1'b1;
            o_tick   <= 1'b0;
        end else begin
            o_clk  <= r_live.en ? (r_cnt > r_live.thresh) : 1'b1;
            o_tick <= w_wrap;

            if (w_commit) begin
                r_live <= r_shadow;
                r_pend <= 1'b0;
                r_cnt  <= r_shadow.en ? w_sh_ph : '0;
            end else if (!r_live.en) begin
                r_cnt <= '0;
            end else if (i_sync) begin
                r_cnt <= w_ph;
            end else if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end

            // Placed last so a write never gets lost behind a commit in the same cycle.
            if (i_wr) begin
                r_shadow <= '{en: i_en, period: i_period, thresh: i_thresh, phase: i_phase};
                r_pend   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_clk_gen_multi.sv
// Multi-channel reference-clock generator: channel-select decode, ready mux and sync fan-out.
// Config handshake is valid/ready; ready drops only for a channel whose previous write is uncommitted.
module udp_clk_gen_multi
    import udp_clk_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = UDP_CLK_WIDTH,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic                cfg_enable,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [WIDTH-1:0]    cfg_thresh,
    input  logic [WIDTH-1:0]    cfg_phase,
    input  logic                sync,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    logic [CHANNELS-1:0] w_wr;

    // Selects beyond CHANNELS read as ready and the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign w_wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        udp_clk_chan #(.WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_wr      (w_wr[g]),
            .i_en      (cfg_enable),
            .i_period  (cfg_period),
            .i_thresh  (cfg_thresh),
            .i_phase   (cfg_phase),
            .i_sync    (sync),
            .o_clk     (clk_out[g]),
            .o_tick    (tick[g]),
            .o_pending (pending[g])
        );
    end

endmodule

// File: tb/tb_udp_clk_gen_multi.sv
// Directed and randomized bench for udp_clk_gen_multi against a counter-free arithmetic model.
module tb_udp_clk_gen_multi;
    import udp_clk_pkg::*;

    localparam int NCH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_ch;
    logic            cfg_enable;
    logic [31:0]     cfg_period;
    logic [31:0]     cfg_thresh;
    logic [31:0]     cfg_phase;
    logic            sync;
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  pending;

    always #5 clk = ~clk;

    udp_clk_gen_multi #(.CHANNELS(NCH), .WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_enable (cfg_enable),
        .cfg_period (cfg_period),
        .cfg_thresh (cfg_thresh),
        .cfg_phase  (cfg_phase),
        .sync       (sync),
        .clk_out    (clk_out),
        .tick       (tick),
        .pending    (pending)
    );

    int tests = 0;
    int fails = 0;

    // Model: count(t) = (ph0 + t - t0) mod period_eff, no per-cycle counter.
    chan_cfg_t      m_live [NCH];
    chan_cfg_t      m_sh   [NCH];
    bit             m_pend [NCH];
    longint         m_t0   [NCH];
    longint         m_ph0  [NCH];
    longint         m_n;
    logic [NCH-1:0] m_clk;
    logic [NCH-1:0] m_tick;

    function automatic longint pe_of(logic [31:0] p);
        return (p < 32'd2) ? 64'd2 : longint'({32'h0, p});
    endfunction

    function automatic longint ph_of(chan_cfg_t c);
        longint ph = longint'({32'h0, c.phase});
        return (ph >= pe_of(c.period)) ? 64'd0 : ph;
    endfunction

    function automatic longint cnt_of(int i);
        if (!m_live[i].en) return 0;
        return (m_ph0[i] + (m_n - m_t0[i])) % pe_of(m_live[i].period);
    endfunction

    function automatic logic [NCH-1:0] pend_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_live[i] = '0; m_sh[i] = '0; m_pend[i] = 0; m_t0[i] = 0; m_ph0[i] = 0;
        end
        m_n = 0; m_clk = '1; m_tick = '0;
    endtask

    task automatic model_edge();
        bit     acc;
        longint c;
        bit     wrap;
        acc = cfg_valid && !m_pend[cfg_ch];
        for (int i = 0; i < NCH; i++) begin
            c    = cnt_of(i);
            wrap = m_live[i].en && (c == pe_of(m_live[i].period) - 1);
            m_clk[i]  = m_live[i].en ? (c > longint'({32'h0, m_live[i].thresh})) : 1'b1;
            m_tick[i] = wrap;
            if (m_pend[i] && (!m_live[i].en || wrap)) begin
                m_live[i] = m_sh[i]; m_pend[i] = 0;
                m_t0[i] = m_n + 1; m_ph0[i] = ph_of(m_live[i]);
            end else if (m_live[i].en && sync) begin
                m_t0[i] = m_n + 1; m_ph0[i] = ph_of(m_live[i]);
            end
        end
        if (acc) begin
            m_sh[cfg_ch].en     = cfg_enable;
            m_sh[cfg_ch].period = cfg_period;
            m_sh[cfg_ch].thresh = cfg_thresh;
            m_sh[cfg_ch].phase  = cfg_phase;
            m_pend[cfg_ch]      = 1;
        end
        m_n++;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cyc();
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
        @(posedge clk);
        model_edge();
        #1;
        check("clk_out", 32'(clk_out), 32'(m_clk));
        check("tick",    32'(tick),    32'(m_tick));
        check("pending", 32'(pending), 32'(pend_vec()));
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input bit en, input logic [31:0] p, input logic [31:0] t,
                      input logic [31:0] ph);
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_enable = en;
        cfg_period = p; cfg_thresh = t; cfg_phase = ph;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        int ones, ticks, guard;
        logic h1 [24];
        logic h2 [24];

        reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_enable = 1'b0;
        cfg_period = '0; cfg_thresh = '0; cfg_phase = '0; sync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_out", 32'(clk_out), 32'hF);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        idle(3);

        // ch0: P=10, T=4 -> 5 low, 5 high, one tick per 10 cycles
        wr(0, 1, 10, 4, 0);
        idle(6);
        ones = 0; ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            ones  += int'(clk_out[0]);
            ticks += int'(tick[0]);
        end
        check("p10_high_cycles", 32'(ones), 32'd10);
        check("p10_ticks", 32'(ticks), 32'd2);

        // Mid-period reprogram holds off until the wrap
        idle(3);
        wr(0, 1, 6, 2, 0);
        check("reprog_pending", 32'(pending[0]), 32'h1);
        cfg_ch = 2'd0;
        #1 check("reprog_ready", 32'(cfg_ready), 32'h0);
        idle(20);

        // ch1/ch2 same shape, phases 0 and 4, then realign with sync
        wr(1, 1, 8, 3, 0);
        wr(2, 1, 8, 3, 4);
        idle(5);
        sync = 1'b1; cyc(); sync = 1'b0;
        cyc();
        for (int k = 0; k < 24; k++) begin
            cyc();
            h1[k] = clk_out[1];
            h2[k] = clk_out[2];
        end
        for (int k = 0; k < 20; k++) check("sync_offset4", 32'(h2[k]), 32'(h1[k+4]));

        // P=0 runs as P=2; phase beyond period loads 0; all-ones threshold stays low
        wr(3, 1, 0, 0, 0);
        idle(6);
        wr(3, 1, 5, 1, 9);
        idle(12);
        wr(1, 1, 8, 32'hFFFF_FFFF, 0);
        idle(12);
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("thresh_max_low", 32'(clk_out[1]), 32'h0);
        end

        // Write landing exactly on ch0's wrap waits a full extra period
        guard = 0;
        while (cnt_of(0) != pe_of(m_live[0].period) - 1 && guard < 20) begin
            cyc(); guard++;
        end
        check("wrap_wait_bound", 32'(guard < 20), 32'h1);
        wr(0, 1, 7, 1, 0);
        check("wrap_write_pending", 32'(pending[0]), 32'h1);
        idle(5);
        check("wrap_still_pending", 32'(pending[0]), 32'h1);
        idle(1);
        check("wrap_committed", 32'(pending[0]), 32'h0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_enable = ($urandom_range(0, 3) != 0);
            cfg_period = $urandom_range(0, 12);
            cfg_thresh = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 13));
            cfg_phase  = $urandom_range(0, 14);
            sync       = ($urandom_range(0, 19) == 0);
            cyc();
        end
        cfg_valid = 1'b0; sync = 1'b0;

        // Asynchronous reset mid-period with a write pending
        wr(0, 1, 9, 3, 2);
        wr(0, 1, 9, 3, 2);
        idle(1);
        wr(2, 1, 11, 5, 1);
        check("pend_before_rst", 32'(pending != '0), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_clk_out", 32'(clk_out), 32'hF);
        check("arst_tick", 32'(tick), 32'h0);
        check("arst_pending", 32'(pending), 32'h0);
        check("arst_ready", 32'(cfg_ready), 32'h1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(10);
        check("post_rst_idle", 32'(clk_out), 32'hF);
        wr(3, 1, 4, 1, 0);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
